// File: rtl/mem_bus_bridge.sv
// -----------------------------------------------------------------------------
// mem_bus_bridge
//
// Bridges the multi-cycle RV32I core's single-cycle re/we memory strobes onto a
// valid/ready request + response-wait system bus. Generates byte enables and
// lane-replicated store data, returns read data shifted down to lane 0, and
// holds the core with stall until the access completes. Misaligned/illegal
// accesses and bus timeouts park the bridge in a sticky fault state that only
// reset clears.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent in REQ+RESP before faulting; 0 disables
//   CNT_W           timeout counter width, must be able to hold TIMEOUT_CYCLES
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   re, we           core read/write strobes, held by the core while stall=1
//   addr             byte address
//   wdata            store data, right-justified in lane 0
//   size             00 byte, 01 half, 10 word, 11 illegal
//   stall            core must hold its state this cycle
//   rdata            read data shifted down to lane 0 (no sign/zero masking)
//   rdata_valid      one-cycle pulse when a read completes
//   fault            sticky misaligned/illegal/timeout indication
//   bus_req_valid    request valid (held until bus_req_ready)
//   bus_req_ready    request accepted when valid & ready
//   bus_we           1 = write, 0 = read
//   bus_addr         word-aligned address
//   bus_be           byte enables
//   bus_wdata        lane-replicated store data
//   bus_resp_valid   response/ack for the accepted request
//   bus_rdata        read data, valid with bus_resp_valid
// -----------------------------------------------------------------------------
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t           state;
  state_t           state_nxt;

  // Fields captured at IDLE->REQ and held stable for the whole access.
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [3:0]       lat_be;
  logic [31:0]      lat_wdata;
  logic [1:0]       lat_off;
  logic [CNT_W-1:0] cnt;

  logic             req_any;
  logic             req_illegal;
  logic [3:0]       be_dec;
  logic [31:0]      wdata_dec;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // ---------------------------------------------------------------------------
  // Request decode: legality, byte enables and lane replication
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    req_any     = re | we;
    req_illegal = (re & we)
                | (size == 2'b11)
                | ((size == 2'b01) & addr[0])
                | ((size == 2'b10) & (addr[1:0] != 2'b00));
    be_dec      = 4'b1111;
    wdata_dec   = wdata;
    case (size)
      2'b00: begin
        be_dec    = 4'b0001 << addr[1:0];
        wdata_dec = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_dec    = 4'b0011 << addr[1:0];
        wdata_dec = {2{wdata[15:0]}};
      end
      default: begin
      end
    endcase
  end

  // The counter holds the number of cycles already spent in REQ/RESP, so the
  // cycle that would make it reach the limit is the last one allowed.
  assign cnt_inc     = cnt + CNT_ONE;
  assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked processes use non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_any) state_nxt = req_illegal ? S_ERR : S_REQ;
      end
      // A handshake in the final allowed REQ cycle does not complete the
      // access, so the timeout wins here.
      S_REQ: begin
        if (timeout_hit)        state_nxt = S_ERR;
        else if (bus_req_ready) state_nxt = S_RESP;
      end
      // A response in the final allowed RESP cycle does complete the access.
      S_RESP: begin
        if (bus_resp_valid)   state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall         = 1'b0;
    rdata_valid   = 1'b0;
    fault         = 1'b0;
    bus_req_valid = 1'b0;
    case (state)
      S_IDLE: stall = req_any;
      S_REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
      end
      S_RESP: stall = 1'b1;
      // Strobes still asserted in DONE belong to the finished access.
      S_DONE: rdata_valid = ~lat_we;
      S_ERR: begin
        stall = 1'b1;
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched request fields, timeout counter and read data
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset too (not just the FSM) because the
  // bus fields and rdata are visible outputs that must read 0 out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      lat_off   <= '0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      if ((state == S_IDLE) && req_any && !req_illegal) begin
        lat_we    <= we;
        lat_addr  <= {addr[31:2], 2'b00};
        lat_be    <= be_dec;
        lat_wdata <= wdata_dec;
        lat_off   <= addr[1:0];
        cnt       <= '0;
      end else if ((state == S_REQ) || (state == S_RESP)) begin
        cnt <= cnt_inc;
      end

      if ((state == S_RESP) && bus_resp_valid && !lat_we)
        rdata <= bus_rdata >> {lat_off, 3'b000};
    end
  end

  assign bus_we    = lat_we;
  assign bus_addr  = lat_addr;
  assign bus_be    = lat_be;
  assign bus_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_bridge
//
// Scoreboard bench for mem_bus_bridge. A driver issues core accesses and, for
// each, pushes the expected bus request and completion into queues computed
// from the access rules (byte-lane arithmetic, word >> 8*offset). A bus-slave
// process answers with per-access ready/response delays, and a monitor pops
// and compares whenever the DUT shows a handshake or a completion. A second
// instance with a short timeout covers fault and mid-access reset behaviour.
// -----------------------------------------------------------------------------
module tb_mem_bus_bridge;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] rdata;
    int          stall_len;
  } done_t;

  typedef struct {
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] word;
  } slv_t;

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
  } ill_t;

  logic        clock;
  logic        reset;
  logic        re, we;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, fault;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_resp_valid;

  logic        t_reset;
  logic        t_re, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_size;
  logic        t_stall;
  logic [31:0] t_rdata;
  logic        t_rdata_valid, t_fault;
  logic        t_bus_req_valid, t_ready, t_bus_we;
  logic [31:0] t_bus_addr, t_bus_wdata, t_bus_rdata;
  logic [3:0]  t_bus_be;
  logic        t_resp_valid;

  req_t        exp_req[$];
  done_t       exp_done[$];
  slv_t        slave_q[$];
  logic [31:0] last_rdata;
  bit          mon_en;
  int          n_checks;
  int          n_pass;

  mem_bus_bridge dut (
    .clock(clock), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .fault(fault), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  mem_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .clock(clock), .reset(t_reset), .re(t_re), .we(t_we), .addr(t_addr),
    .wdata(t_wdata), .size(t_size), .stall(t_stall), .rdata(t_rdata),
    .rdata_valid(t_rdata_valid), .fault(t_fault), .bus_req_valid(t_bus_req_valid),
    .bus_req_ready(t_ready), .bus_we(t_bus_we), .bus_addr(t_bus_addr),
    .bus_be(t_bus_be), .bus_wdata(t_bus_wdata), .bus_resp_valid(t_resp_valid),
    .bus_rdata(t_bus_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + driver for one legal access on the main instance
  // ---------------------------------------------------------------------------
  task automatic do_txn(input bit is_wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [31:0] word,
                        input int rdy, input int rsp, input bit keep, input int gap);
    req_t        r;
    done_t       d;
    slv_t        s;
    int          off, nb, waited;
    logic [31:0] lane;
    off    = int'(a[1:0]);
    nb     = 1 << sz;
    r.we   = is_wr;
    r.addr = a & 32'hFFFF_FFFC;
    r.be   = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nb) r.be[i] = 1'b1;
    case (sz)
      2'b00:   begin lane = {24'b0, wd[7:0]};  r.wdata = lane * 32'h0101_0101; end
      2'b01:   begin lane = {16'b0, wd[15:0]}; r.wdata = lane * 32'h0001_0001; end
      default: r.wdata = wd;
    endcase
    if (!is_wr) last_rdata = word >> (8 * off);
    d.is_rd     = !is_wr;
    d.rdata     = last_rdata;
    d.stall_len = 3 + rdy + rsp;
    s.rdy_dly   = rdy;
    s.rsp_dly   = rsp;
    s.word      = word;
    exp_req.push_back(r);
    exp_done.push_back(d);
    slave_q.push_back(s);

    re = !is_wr; we = is_wr; addr = a; size = sz; wdata = wd;
    waited = 0;
    do begin
      @(posedge clock); #1;
      waited++;
    end while (stall && waited < 60);
    if (stall) check("txn_completes_in_budget", 72'(stall), 72'(0));
    if (keep) begin @(posedge clock); #1; end
    re = 1'b0; we = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  // ---------------------------------------------------------------------------
  // Bus slave for the main instance
  // ---------------------------------------------------------------------------
  initial begin
    slv_t s;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_rdata      = '0;
    forever begin
      @(posedge clock); #1;
      if (bus_req_valid && slave_q.size() > 0) begin
        s = slave_q.pop_front();
        for (int i = 0; i < s.rdy_dly; i++) begin
          bus_req_ready  = 1'b0;
          bus_resp_valid = ($urandom_range(0, 3) == 0);  // stray ack, must be ignored
          bus_rdata      = $urandom;
          @(posedge clock); #1;
        end
        bus_resp_valid = 1'b0;
        bus_req_ready  = 1'b1;
        @(posedge clock); #1;
        bus_req_ready = 1'b0;
        for (int i = 0; i < s.rsp_dly; i++) begin @(posedge clock); #1; end
        bus_resp_valid = 1'b1;
        bus_rdata      = s.word;
        @(posedge clock); #1;
        bus_resp_valid = 1'b0;
      end else begin
        bus_req_ready  = 1'($urandom_range(0, 1));
        bus_resp_valid = ($urandom_range(0, 5) == 0);
        bus_rdata      = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard for the main instance
  // ---------------------------------------------------------------------------
  initial begin
    req_t        r;
    done_t       d;
    int          run;
    bit          prev_wait;
    logic [68:0] prev_fields;
    run = 0; prev_wait = 1'b0; prev_fields = '0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        run = 0; prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check("req_valid_held", 72'(bus_req_valid), 72'(1));
          check("req_fields_stable", 72'({bus_we, bus_addr, bus_be, bus_wdata}), 72'(prev_fields));
        end
        if (bus_req_valid && bus_req_ready) begin
          if (exp_req.size() == 0) begin
            check("unexpected_handshake", 72'(1), 72'(0));
          end else begin
            r = exp_req.pop_front();
            check("bus_we", 72'(bus_we), 72'(r.we));
            check("bus_addr", 72'(bus_addr), 72'(r.addr));
            check("bus_be", 72'(bus_be), 72'(r.be));
            if (r.we) check("bus_wdata", 72'(bus_wdata), 72'(r.wdata));
          end
        end
        prev_wait   = bus_req_valid && !bus_req_ready;
        prev_fields = {bus_we, bus_addr, bus_be, bus_wdata};

        if (stall) begin
          run++;
        end else if (run > 0) begin
          if (exp_done.size() == 0) begin
            check("unexpected_completion", 72'(1), 72'(0));
          end else begin
            d = exp_done.pop_front();
            check("stall_cycles", 72'(run), 72'(d.stall_len));
            check("rdata_valid_at_done", 72'(rdata_valid), 72'(d.is_rd));
            check("rdata", 72'(rdata), 72'(d.rdata));
            check("no_fault", 72'(fault), 72'(0));
          end
          run = 0;
        end else begin
          check("rdata_valid_idle", 72'(rdata_valid), 72'(0));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    ill_t        ill[5];
    int          n;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] a;
    int          rdy, rsp;

    n_checks = 0; n_pass = 0; mon_en = 1'b0; last_rdata = '0;
    reset = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0;
    t_reset = 1'b1; t_re = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_size = '0;
    t_ready = 1'b0; t_resp_valid = 1'b0; t_bus_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; t_reset = 1'b0;

    // Reset state
    check("rst_stall", 72'(stall), 72'(0));
    check("rst_fault", 72'(fault), 72'(0));
    check("rst_rdata", 72'(rdata), 72'(0));
    check("rst_rdata_valid", 72'(rdata_valid), 72'(0));
    check("rst_req_valid", 72'(bus_req_valid), 72'(0));
    check("rst_bus_fields", 72'({bus_we, bus_addr, bus_be, bus_wdata}), 72'(0));
    check("rst_to_outputs", 72'({t_stall, t_fault, t_rdata_valid, t_bus_req_valid, t_rdata}), 72'(0));

    mon_en = 1'b1;
    // Directed: word read, byte write to lane 3, half read from upper half,
    // ready held low 5 cycles
    do_txn(1'b0, 32'h0000_0100, 2'b10, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 1);
    do_txn(1'b1, 32'h0000_0203, 2'b00, 32'h0000_00A5, 32'h5555_5555, 0, 0, 1'b0, 1);
    do_txn(1'b0, 32'h0000_0012, 2'b01, 32'h0, 32'h1234_ABCD, 0, 0, 1'b0, 1);
    do_txn(1'b1, 32'h0000_03C6, 2'b01, 32'h9876_BEEF, 32'h0, 5, 2, 1'b1, 0);
    do_txn(1'b0, 32'h0000_0041, 2'b00, 32'h0, 32'hA1B2_C3D4, 5, 0, 1'b0, 0);

    for (int k = 0; k < 150; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      rdy = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      rsp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_txn(wr, a, sz, $urandom, $urandom, rdy, rsp, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end
    repeat (3) begin @(posedge clock); #1; end
    check("req_queue_drained", 72'(exp_req.size()), 72'(0));
    check("done_queue_drained", 72'(exp_done.size()), 72'(0));
    check("slave_queue_drained", 72'(slave_q.size()), 72'(0));
    mon_en = 1'b0;

    // Illegal accesses: each must fault next cycle, stay faulted, never
    // request the bus, and clear on reset.
    ill[0].r = 1'b1; ill[0].w = 1'b0; ill[0].sz = 2'b10; ill[0].a = 32'h0000_0102;
    ill[1].r = 1'b1; ill[1].w = 1'b1; ill[1].sz = 2'b10; ill[1].a = 32'h0000_0100;
    ill[2].r = 1'b1; ill[2].w = 1'b0; ill[2].sz = 2'b11; ill[2].a = 32'h0000_0100;
    ill[3].r = 1'b0; ill[3].w = 1'b1; ill[3].sz = 2'b01; ill[3].a = 32'h0000_0101;
    ill[4].r = 1'b0; ill[4].w = 1'b1; ill[4].sz = 2'b10; ill[4].a = 32'h0000_0201;
    for (int p = 0; p < 5; p++) begin
      re = ill[p].r; we = ill[p].w; size = ill[p].sz; addr = ill[p].a; wdata = $urandom;
      @(posedge clock); #1;
      check("err_fault", 72'(fault), 72'(1));
      check("err_stall", 72'(stall), 72'(1));
      check("err_no_req", 72'(bus_req_valid), 72'(0));
      repeat (3) begin @(posedge clock); #1; end
      check("err_sticky", 72'({fault, stall, bus_req_valid}), 72'(3'b110));
      re = 1'b0; we = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("err_reset_clears", 72'({fault, stall, bus_req_valid}), 72'(0));
      check("err_reset_rdata", 72'(rdata), 72'(0));
    end

    // Timeout with ready never asserted: 4 cycles in REQ, then fault.
    t_size = 2'b10; t_addr = 32'h0000_0040; t_ready = 1'b0; t_re = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (t_fault) break;
      n++;
    end
    check("to_req_cycles", 72'(n), 72'(4));
    check("to_req_state", 72'({t_fault, t_stall, t_bus_req_valid}), 72'(3'b110));
    t_re = 1'b0; t_reset = 1'b1;
    @(posedge clock); #1;
    t_reset = 1'b0;
    check("to_reset_clears", 72'(t_fault), 72'(0));

    // Timeout after acceptance, response never arrives.
    t_ready = 1'b1; t_re = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (t_fault) break;
      n++;
    end
    check("to_resp_cycles", 72'(n), 72'(4));
    t_re = 1'b0; t_reset = 1'b1;
    @(posedge clock); #1;
    t_reset = 1'b0;

    // Reset while waiting in RESP, then a late response must be ignored.
    t_addr = 32'h0000_0044; t_size = 2'b10; t_re = 1'b1;
    @(posedge clock); #1;
    check("mid_req", 72'({t_stall, t_bus_req_valid}), 72'(2'b11));
    @(posedge clock); #1;
    check("mid_resp", 72'({t_stall, t_bus_req_valid}), 72'(2'b10));
    t_reset = 1'b1; t_re = 1'b0;
    @(posedge clock); #1;
    t_reset = 1'b0;
    check("mid_reset_idle", 72'({t_stall, t_bus_req_valid}), 72'(0));
    t_resp_valid = 1'b1; t_bus_rdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    t_resp_valid = 1'b0;
    check("late_resp_ignored", 72'({t_rdata_valid, t_stall, t_fault}), 72'(0));
    check("late_resp_rdata", 72'(t_rdata), 72'(0));

    // A normal byte read at lane 1 still works afterwards.
    t_addr = 32'h0000_0045; t_size = 2'b00; t_re = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    t_resp_valid = 1'b1; t_bus_rdata = 32'h1122_3344;
    @(posedge clock); #1;
    t_resp_valid = 1'b0; t_re = 1'b0;
    check("after_reset_rdata_valid", 72'(t_rdata_valid), 72'(1));
    check("after_reset_rdata", 72'(t_rdata), 72'(32'h0011_2233));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
